// File: rtl/kyber_pkg.sv
// Shared Kyber constants, compression-width modes and the unpacker state type.
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int COEF_W  = 12;

  // Run-time compression width selector: du/dv of every Kyber parameter set.
  typedef enum logic [1:0] {
    D_4  = 2'd0,
    D_5  = 2'd1,
    D_10 = 2'd2,
    D_11 = 2'd3
  } d_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Number of stream bits per coefficient for a given mode.
  function automatic logic [3:0] d_width(input d_mode_e mode);
    logic [3:0] w;
    case (mode)
      D_4:     w = 4'd4;
      D_5:     w = 4'd5;
      D_10:    w = 4'd10;
      default: w = 4'd11;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/kyber_decompress_d.sv
// Decompress_d: maps a d-bit value x onto Z_q as round(q * x / 2^d),
// with ties rounded up. Purely combinational.
module kyber_decompress_d
  import kyber_pkg::*;
(
  input  d_mode_e           d_mode,
  input  logic [10:0]       x,
  output logic [COEF_W-1:0] coef
);

  logic [3:0]  d_w;
  logic [22:0] prod;
  logic [23:0] half;
  logic [23:0] sum;
  logic [23:0] shifted;

  // Multiply, add half an LSB of the result, then drop the d fraction bits.
  always_comb begin
    d_w     = d_width(d_mode);
    prod    = 23'(x) * 23'(KYBER_Q);
    half    = 24'd1 << (d_w - 4'd1);
    sum     = {1'b0, prod} + half;
    shifted = sum >> d_w;
    coef    = shifted[COEF_W-1:0];
  end

endmodule

// File: rtl/kyber_poly_decompress.sv
// Streaming ciphertext unpacker: ByteDecode_d followed by Decompress_d over
// a frame of 1..MAX_POLY polynomials, bytes in, 12-bit coefficients out.
module kyber_poly_decompress
  import kyber_pkg::*;
#(
  parameter int MAX_POLY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        d_mode,
  input  logic [2:0]        n_poly,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_coef,
  output logic [7:0]        out_idx,
  output logic [1:0]        out_poly,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q,     state_d;
  d_mode_e           d_mode_q,    d_mode_d;
  logic [2:0]        n_poly_q,    n_poly_d;
  logic [23:0]       buf_q,       buf_d;
  logic [4:0]        fill_q,      fill_d;
  logic [10:0]       byte_cnt_q,  byte_cnt_d;
  logic [9:0]        coef_cnt_q,  coef_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [COEF_W-1:0] out_coef_q,  out_coef_d;
  logic [7:0]        out_idx_q,   out_idx_d;
  logic [1:0]        out_poly_q,  out_poly_d;
  logic              out_last_q,  out_last_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;

  logic [3:0]        d_w;
  logic [5:0]        d_times_n;
  logic [10:0]       bytes_total;
  logic [9:0]        last_coef;
  logic              run;
  logic              in_ready_w;
  logic              acc;
  logic              ext;
  logic              out_hs;
  logic              n_ok;
  logic [10:0]       x_mask;
  logic [10:0]       x;
  logic [COEF_W-1:0] coef;
  logic [4:0]        fill_ext;
  logic [23:0]       buf_ext;

  // Frame geometry, handshake qualifiers and the candidate coefficient.
  always_comb begin
    d_w         = d_width(d_mode_q);
    d_times_n   = 6'(d_w) * 6'(n_poly_q);
    bytes_total = {d_times_n, 5'd0};
    last_coef   = {2'(n_poly_q - 3'd1), 8'hFF};
    run         = (state_q == ST_RUN);
    in_ready_w  = run && (byte_cnt_q != bytes_total) && (fill_q <= 5'd16);
    acc         = in_valid && in_ready_w;
    out_hs      = out_valid_q && out_ready;
    ext         = run && (fill_q >= {1'b0, d_w}) && (!out_valid_q || out_ready);
    x_mask      = 11'((12'd1 << d_w) - 12'd1);
    x           = buf_q[10:0] & x_mask;
    n_ok        = (n_poly != 3'd0) && (int'(n_poly) <= MAX_POLY);
  end

  kyber_decompress_d u_decompress (
    .d_mode (d_mode_q),
    .x      (x),
    .coef   (coef)
  );

  // Next-state: bit buffer shift/fill, output register and FSM.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; an incomplete assignment here would infer a latch.
    state_d     = state_q;
    d_mode_d    = d_mode_q;
    n_poly_d    = n_poly_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    byte_cnt_d  = byte_cnt_q;
    coef_cnt_d  = coef_cnt_q;
    out_valid_d = out_valid_q;
    out_coef_d  = out_coef_q;
    out_idx_d   = out_idx_q;
    out_poly_d  = out_poly_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // Extraction consumes the low d bits; the new byte lands just above
    // whatever remains, so both may happen in one cycle.
    fill_ext = ext ? (fill_q - {1'b0, d_w}) : fill_q;
    buf_ext  = ext ? (buf_q >> d_w) : buf_q;
    buf_d    = buf_ext;
    fill_d   = fill_ext;
    if (acc) begin
      buf_d      = buf_ext | (24'(in_byte) << fill_ext);
      fill_d     = fill_ext + 5'd8;
      byte_cnt_d = byte_cnt_q + 11'd1;
    end

    if (ext) begin
      out_valid_d = 1'b1;
      out_coef_d  = coef;
      out_idx_d   = coef_cnt_q[7:0];
      out_poly_d  = coef_cnt_q[9:8];
      out_last_d  = (coef_cnt_q == last_coef);
      coef_cnt_d  = coef_cnt_q + 10'd1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_ok) begin
            state_d    = ST_RUN;
            d_mode_d   = d_mode_e'(d_mode);
            n_poly_d   = n_poly;
            buf_d      = '0;
            fill_d     = '0;
            byte_cnt_d = '0;
            coef_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        if (out_hs && out_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      d_mode_q    <= D_4;
      n_poly_q    <= 3'd1;
      buf_q       <= '0;
      fill_q      <= '0;
      byte_cnt_q  <= '0;
      coef_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_coef_q  <= '0;
      out_idx_q   <= '0;
      out_poly_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every flop sample the pre-edge
      // value of its neighbours, independent of statement order.
      state_q     <= state_d;
      d_mode_q    <= d_mode_d;
      n_poly_q    <= n_poly_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      byte_cnt_q  <= byte_cnt_d;
      coef_cnt_q  <= coef_cnt_d;
      out_valid_q <= out_valid_d;
      out_coef_q  <= out_coef_d;
      out_idx_q   <= out_idx_d;
      out_poly_q  <= out_poly_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_w;
  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;
  assign out_idx   = out_idx_q;
  assign out_poly  = out_poly_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_kyber_poly_decompress.sv
// Scoreboard bench: each frame is built from chosen coefficient values x,
// packed LSB-first into bytes, and the expected coefficients are queued.
`timescale 1ns/1ps
module tb_kyber_poly_decompress;

  localparam int PAT_ALT  = 0;  // x alternates 1,2 (bytes 0x21 for d=4)
  localparam int PAT_MAX  = 1;  // x = 2^d-1 (all bytes 0xFF)
  localparam int PAT_RAND = 2;  // uniform random x
  localparam int PAT_D11  = 3;  // x0=0, x1=1024, rest random
  localparam int N_EXTRA  = 3;  // bytes offered beyond the frame

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  d_mode;
  logic [2:0]  n_poly;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_coef;
  logic [7:0]  out_idx;
  logic [1:0]  out_poly;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    int coef;
    int idx;
    int poly;
    int last;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] tx_q[$];
  int total = 0;
  int bad = 0;
  int accepted = 0;
  int done_seen = 0;
  int frames = 0;
  bit hold = 0;
  bit rand_ready = 0;
  bit rand_valid = 0;
  bit expect_done = 0;

  kyber_poly_decompress #(.MAX_POLY(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .d_mode    (d_mode),
    .n_poly    (n_poly),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .out_poly  (out_poly),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int dw(input int mode);
    case (mode)
      0: return 4;
      1: return 5;
      2: return 10;
      default: return 11;
    endcase
  endfunction

  // Reference: nearest integer to q*x/2^d, halves rounded up.
  function automatic int ref_coef(input int x, input int d);
    return (2 * 3329 * x + (1 << d)) / (1 << (d + 1));
  endfunction

  // Input and ready drivers, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    in_valid  = (tx_q.size() > 0) && (!rand_valid || ($urandom_range(0, 3) != 0));
    in_byte   = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    out_ready = !hold && (!rand_ready || ($urandom_range(0, 1) == 1));
  end

  // A byte is taken at the next rising edge when valid and ready at midcycle.
  always @(negedge clk) begin
    if (in_valid && in_ready && tx_q.size() > 0) begin
      void'(tx_q.pop_front());
      accepted++;
    end
  end

  // Monitor: compares each delivered coefficient against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (expect_done) begin
      check("done_pulse", int'(done), 1);
      check("busy_fall", int'(busy), 0);
      expect_done = 0;
    end
    if (done) done_seen++;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_coef", int'(out_valid), 0);
      end else begin
        e = sb.pop_front();
        check("coef", int'(out_coef), e.coef);
        check("idx", int'(out_idx), e.idx);
        check("poly", int'(out_poly), e.poly);
        check("last", int'(out_last), e.last);
        if (e.last != 0) begin
          check("in_ready_at_end", int'(in_ready), 0);
          expect_done = 1;
        end
      end
    end
  end

  // Build the frame: choose x values, queue expectations, pack the bytes.
  task automatic queue_frame(input int mode, input int n, input int pat);
    int d;
    int ncoef;
    int x;
    bit bits[$];
    logic [7:0] b;
    exp_t e;
    d = dw(mode);
    ncoef = 256 * n;
    for (int i = 0; i < ncoef; i++) begin
      case (pat)
        PAT_ALT: x = (i % 2 == 0) ? 1 : 2;
        PAT_MAX: x = (1 << d) - 1;
        PAT_D11: x = (i == 0) ? 0 : (i == 1) ? 1024 : int'($urandom_range(0, (1 << d) - 1));
        default: x = int'($urandom_range(0, (1 << d) - 1));
      endcase
      e.coef = ref_coef(x, d);
      e.idx  = i % 256;
      e.poly = i / 256;
      e.last = (i == ncoef - 1) ? 1 : 0;
      sb.push_back(e);
      for (int k = 0; k < d; k++) bits.push_back(((x >> k) & 1) == 1);
    end
    for (int j = 0; j < bits.size() / 8; j++) begin
      for (int k = 0; k < 8; k++) b[k] = bits[8 * j + k];
      tx_q.push_back(b);
    end
    for (int j = 0; j < N_EXTRA; j++) tx_q.push_back(8'hA5);
  endtask

  task automatic pulse_start(input int mode, input int n);
    @(posedge clk); #1;
    start  = 1'b1;
    d_mode = 2'(mode);
    n_poly = 3'(n);
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic run_frame(input int mode, input int n, input int pat, input bit stall);
    int nb;
    int budget;
    int prev_done;
    nb = 32 * dw(mode) * n;
    accepted = 0;
    prev_done = done_seen;
    queue_frame(mode, n, pat);
    pulse_start(mode, n);
    @(negedge clk);
    check("busy_rise", int'(busy), 1);
    check("no_err_on_start", int'(err), 0);
    pulse_start(mode, 0);
    @(negedge clk);
    check("start_while_busy_no_err", int'(err), 0);
    check("start_while_busy_stays", int'(busy), 1);
    if (stall) begin
      budget = 0;
      while (sb.size() >= 128 && budget < 5000) begin
        @(negedge clk);
        budget++;
      end
      hold = 1;
      repeat (11) @(negedge clk);
      check("stall_in_ready_low", int'(in_ready), 0);
      check("stall_out_held", int'(out_valid), 1);
      hold = 0;
    end
    budget = 0;
    while (done_seen == prev_done && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    check("frame_completes", int'(budget < 20000), 1);
    @(negedge clk);
    frames++;
    check("sb_drained", sb.size(), 0);
    check("bytes_accepted", accepted, nb);
    check("extra_bytes_refused", tx_q.size(), N_EXTRA);
    check("idle_in_ready", int'(in_ready), 0);
    tx_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_coef"}, int'(out_coef), 0);
    check({tag, "_out_idx"}, int'(out_idx), 0);
    check({tag, "_out_poly"}, int'(out_poly), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  task automatic bad_start(input int n);
    pulse_start(2, n);
    @(negedge clk);
    check("err_pulse", int'(err), 1);
    check("err_busy_low", int'(busy), 0);
    check("err_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    check("err_one_cycle", int'(err), 0);
    check("err_still_idle", int'(busy), 0);
  endtask

  initial begin
    int budget;
    rst       = 1'b0;
    start     = 1'b0;
    d_mode    = 2'd0;
    n_poly    = 3'd1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    run_frame(0, 1, PAT_ALT, 0);
    run_frame(2, 1, PAT_MAX, 0);
    run_frame(3, 1, PAT_D11, 0);
    run_frame(1, 1, PAT_MAX, 1);

    rand_ready = 1;
    rand_valid = 1;
    run_frame(2, 3, PAT_RAND, 0);
    run_frame(3, 4, PAT_RAND, 0);
    run_frame(0, 2, PAT_RAND, 0);
    rand_ready = 0;
    rand_valid = 0;

    bad_start(0);
    bad_start(5);

    // Reset in the middle of a frame, then a fresh frame must decode.
    queue_frame(2, 2, PAT_RAND);
    pulse_start(2, 2);
    budget = 0;
    while (sb.size() >= 300 && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check("midframe_reached", int'(budget < 5000), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    sb.delete();
    tx_q.delete();
    expect_done = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("after_rst_idle", int'(busy), 0);
    run_frame(2, 2, PAT_RAND, 0);

    check("done_count", done_seen, frames);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
